// File: rtl/seg_defs.sv
// Shared constants for the six-digit seven-segment display path.
package seg_defs;

  localparam int SEG_DIGITS = 6;
  localparam int SEG_DATA_W = 20;
  localparam int SEG_MAX    = 999_999;

  localparam logic [SEG_DIGITS-1:0] POINT_NONE = '0;

  // Count direction as seen on the up_dn pin.
  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

endpackage

// File: rtl/bcd_display_counter_tick_gen.sv
// Prescaler: divides clk by CLK_FREQ/TICK_HZ and emits a one-clock step tick.
// The count only advances while en is high. A pause holds the count and drops tick.
module tick_gen #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int DIV = CLK_FREQ / TICK_HZ;
  localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next prescaler state; clear and pause both keep tick low.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Prescaler registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/bcd_display_counter.sv
// Up/down sign-magnitude display counter feeding the seg_led driver.
// Steps once per prescaler tick, bounded to +/-MAX_COUNT, with wrap or saturate.
module bcd_display_counter
  import seg_defs::*;
#(
  parameter int                CLK_FREQ  = 50_000_000,
  parameter int                TICK_HZ   = 100,
  parameter int                DATA_W    = SEG_DATA_W,
  parameter int                MAX_COUNT = SEG_MAX,
  parameter int                DIGITS    = SEG_DIGITS,
  parameter logic [DIGITS-1:0] POINT_POS = '0,
  parameter bit                SIGNED_EN = 1'b1,
  parameter bit                WRAP_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cnt_en,
  input  logic              up_dn,
  input  logic              clr,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              load_neg,
  output logic [DATA_W-1:0] data,
  output logic [DIGITS-1:0] point,
  output logic              en,
  output logic              sign,
  output logic              tick,
  output logic              wrap
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(MAX_COUNT);

  logic [DATA_W-1:0] data_q;
  logic [DIGITS-1:0] point_q;
  logic              en_q, sign_q, wrap_q;
  logic              tick_w;

  logic [DATA_W-1:0] ld_mag_d;
  logic              ld_neg_d;
  logic [DATA_W+1:0] step_d;

  // Returns {wrap, sign, magnitude} after one signed +/-1 step.
  // Magnitude never leaves 0..MAX_COUNT; zero is always positive.
  function automatic logic [DATA_W+1:0] next_val(input logic [DATA_W-1:0] mag,
                                                 input logic              neg,
                                                 input logic              up);
    logic [DATA_W-1:0] m;
    logic              s;
    logic              w;
    m = mag;
    s = neg;
    w = 1'b0;
    if (up) begin
      if (neg) begin
        m = mag - DATA_W'(1);
        s = (m != '0);
      end else if (mag >= MAX_V) begin
        w = 1'b1;
        if (!WRAP_EN) begin
          m = MAX_V;
        end else if (SIGNED_EN) begin
          m = MAX_V;
          s = 1'b1;
        end else begin
          m = '0;
        end
      end else begin
        m = mag + DATA_W'(1);
      end
    end else begin
      if (!neg && mag == '0) begin
        if (SIGNED_EN) begin
          m = DATA_W'(1);
          s = 1'b1;
        end else begin
          w = 1'b1;
          m = WRAP_EN ? MAX_V : '0;
        end
      end else if (!neg) begin
        m = mag - DATA_W'(1);
      end else if (mag >= MAX_V) begin
        w = 1'b1;
        m = MAX_V;
        s = !WRAP_EN;
      end else begin
        m = mag + DATA_W'(1);
      end
    end
    return {w, s, m};
  endfunction

  tick_gen #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .sync_clr(clr | load),
    .tick    (tick_w)
  );

  // Load value clamped to the displayable range; a zero load is never negative.
  always_comb begin
    ld_mag_d = (load_val > MAX_V) ? MAX_V : load_val;
    ld_neg_d = SIGNED_EN && load_neg && (ld_mag_d != '0);
    step_d   = next_val(data_q, sign_q, dir_e'(up_dn) == DIR_UP);
  end

  // Counter, sign and display-control registers: rst > clr > load > step.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      sign_q  <= 1'b0;
      wrap_q  <= 1'b0;
      en_q    <= 1'b0;
      point_q <= '0;
    end else begin
      en_q    <= 1'b1;
      point_q <= POINT_POS;
      wrap_q  <= 1'b0;
      if (clr) begin
        data_q <= '0;
        sign_q <= 1'b0;
      end else if (load) begin
        data_q <= ld_mag_d;
        sign_q <= ld_neg_d;
      end else if (tick_w && cnt_en) begin
        data_q <= step_d[DATA_W-1:0];
        sign_q <= step_d[DATA_W];
        wrap_q <= step_d[DATA_W+1];
      end
    end
  end

  assign data  = data_q;
  assign point = point_q;
  assign en    = en_q;
  assign sign  = sign_q;
  assign tick  = tick_w;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter with DIV=4 and MAX_COUNT=15.
// Three instances share stimulus: unsigned/wrap, signed/wrap, signed/saturate.
module tb_bcd_display_counter;

  localparam logic [5:0] PPOS = 6'b100100;

  logic        clk = 1'b0;
  logic        rst, cnt_en, up_dn, clr, load, load_neg;
  logic [19:0] load_val;

  logic [19:0] data_u, data_s, data_t;
  logic [5:0]  point_u, point_s, point_t;
  logic        en_u, en_s, en_t;
  logic        sign_u, sign_s, sign_t;
  logic        tick_u, tick_s, tick_t;
  logic        wrap_u, wrap_s, wrap_t;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_display_counter #(
    .CLK_FREQ(8), .TICK_HZ(2), .DATA_W(20), .MAX_COUNT(15), .DIGITS(6),
    .POINT_POS(PPOS), .SIGNED_EN(1'b0), .WRAP_EN(1'b1)
  ) dut_u (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .load_neg(load_neg), .data(data_u), .point(point_u),
    .en(en_u), .sign(sign_u), .tick(tick_u), .wrap(wrap_u)
  );

  bcd_display_counter #(
    .CLK_FREQ(8), .TICK_HZ(2), .DATA_W(20), .MAX_COUNT(15), .DIGITS(6),
    .POINT_POS(PPOS), .SIGNED_EN(1'b1), .WRAP_EN(1'b1)
  ) dut_s (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .load_neg(load_neg), .data(data_s), .point(point_s),
    .en(en_s), .sign(sign_s), .tick(tick_s), .wrap(wrap_s)
  );

  bcd_display_counter #(
    .CLK_FREQ(8), .TICK_HZ(2), .DATA_W(20), .MAX_COUNT(15), .DIGITS(6),
    .POINT_POS(PPOS), .SIGNED_EN(1'b1), .WRAP_EN(1'b0)
  ) dut_t (
    .clk(clk), .rst(rst), .cnt_en(cnt_en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .load_neg(load_neg), .data(data_t), .point(point_t),
    .en(en_t), .sign(sign_t), .tick(tick_t), .wrap(wrap_t)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cnt_en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0; load_neg = 1'b0;
    cyc(3);
    chk("rst_data",  32'(data_u),  0);
    chk("rst_sign",  32'(sign_u),  0);
    chk("rst_en",    32'(en_u),    0);
    chk("rst_point", 32'(point_u), 0);
    chk("rst_tick",  32'(tick_u),  0);
    chk("rst_wrap",  32'(wrap_u),  0);

    // Test 1: count up from reset, first step five clocks after enable.
    rst = 1'b0; cnt_en = 1'b1; up_dn = 1'b1;
    cyc(1);
    chk("t1_en",     32'(en_u),    1);
    chk("t1_point",  32'(point_u), 32'(PPOS));
    chk("t1_data0",  32'(data_u),  0);
    cyc(2);
    chk("t1_notick", 32'(tick_u),  0);
    cyc(1);
    chk("t1_tick",   32'(tick_u),  1);
    chk("t1_pre",    32'(data_u),  0);
    cyc(1);
    chk("t1_data1",  32'(data_u),  1);
    chk("t1_tickoff",32'(tick_u),  0);
    cyc(3);
    chk("t1_tick2",  32'(tick_u),  1);
    cyc(1);
    chk("t1_data2",  32'(data_u),  2);
    chk("t1_data2s", 32'(data_s),  2);

    // Test 2: unsigned wrap 14 -> 15 -> 0.
    load_val = 20'd14; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("t2_load",   32'(data_u),  14);
    chk("t2_ldtick", 32'(tick_u),  0);
    cyc(5);
    chk("t2_15",     32'(data_u),  15);
    chk("t2_nowrap", 32'(wrap_u),  0);
    cyc(4);
    chk("t2_0",      32'(data_u),  0);
    chk("t2_wrap",   32'(wrap_u),  1);
    cyc(1);
    chk("t2_wrapoff",32'(wrap_u),  0);

    // Test 3: signed down through zero, then back up.
    load_val = 20'd1; load_neg = 1'b0; load = 1'b1; up_dn = 1'b0;
    cyc(1);
    load = 1'b0;
    chk("t3_ld",     32'(data_s),  1);
    cyc(5);
    chk("t3_z",      32'(data_s),  0);
    chk("t3_zs",     32'(sign_s),  0);
    cyc(4);
    chk("t3_m1",     32'(data_s),  1);
    chk("t3_m1s",    32'(sign_s),  1);
    chk("t3_m1w",    32'(wrap_s),  0);
    cyc(4);
    chk("t3_m2",     32'(data_s),  2);
    chk("t3_m2s",    32'(sign_s),  1);
    up_dn = 1'b1;
    cyc(4);
    chk("t3_u1",     32'(data_s),  1);
    chk("t3_u1s",    32'(sign_s),  1);
    cyc(4);
    chk("t3_u0",     32'(data_s),  0);
    chk("t3_u0s",    32'(sign_s),  0);

    // Test 4: saturate at +15, wrap pulses on each attempted step.
    load_val = 20'd15; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("t4_ld",     32'(data_t),  15);
    cyc(5);
    chk("t4_d1",     32'(data_t),  15);
    chk("t4_w1",     32'(wrap_t),  1);
    cyc(1);
    chk("t4_w1off",  32'(wrap_t),  0);
    cyc(3);
    chk("t4_w2",     32'(wrap_t),  1);
    cyc(4);
    chk("t4_d3",     32'(data_t),  15);
    chk("t4_w3",     32'(wrap_t),  1);
    chk("t4_s3",     32'(sign_t),  0);

    // Test 5: load clamp, clr over load, load on a tick cycle.
    load_val = 20'd40; load_neg = 1'b1; load = 1'b1;
    cyc(1);
    chk("t5_clamp",  32'(data_u),  15);
    chk("t5_nosign", 32'(sign_u),  0);
    chk("t5_sclamp", 32'(data_s),  15);
    chk("t5_ssign",  32'(sign_s),  1);
    clr = 1'b1; load_val = 20'd7; load_neg = 1'b0;
    cyc(1);
    clr = 1'b0; load = 1'b0;
    chk("t5_clr",    32'(data_u),  0);
    chk("t5_clrs",   32'(data_s),  0);
    cyc(4);
    chk("t5_tick",   32'(tick_u),  1);
    load_val = 20'd5; load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("t5_nostep", 32'(data_u),  5);
    chk("t5_ltick",  32'(tick_u),  0);
    cyc(5);
    chk("t5_step",   32'(data_u),  6);

    // Test 6: pause holds everything; drop cnt_en on a tick; rst mid-count.
    cyc(2);
    cnt_en = 1'b0;
    cyc(10);
    chk("t6_hold",   32'(data_u),  6);
    chk("t6_htick",  32'(tick_u),  0);
    cnt_en = 1'b1;
    cyc(1);
    chk("t6_resume", 32'(tick_u),  1);
    cyc(1);
    chk("t6_d7",     32'(data_u),  7);
    cyc(3);
    chk("t6_tick",   32'(tick_u),  1);
    cnt_en = 1'b0;
    cyc(3);
    chk("t6_drop",   32'(data_u),  7);
    cnt_en = 1'b1;
    cyc(4);
    chk("t6_tick2",  32'(tick_u),  1);
    chk("t6_d7b",    32'(data_u),  7);
    cyc(1);
    chk("t6_d8",     32'(data_u),  8);
    rst = 1'b1;
    cyc(1);
    chk("t6_rdata",  32'(data_u),  0);
    chk("t6_ren",    32'(en_u),    0);
    chk("t6_rpoint", 32'(point_u), 0);
    chk("t6_rtick",  32'(tick_u),  0);
    chk("t6_rdatat", 32'(data_t),  0);
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
